// File: rtl/mining_pkg.sv
// Shared definitions for the miner and its result reporting path.
package mining_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_e;

  typedef enum logic {
    SEQ_IDLE,
    SEQ_SEND
  } seq_state_e;

  // Number of hash-pipeline stages between nonce issue and the hit flag.
  function automatic logic [31:0] nonce_offset(input int unsigned loop_log2);
    case (loop_log2)
      0:       nonce_offset = 32'd131;
      1:       nonce_offset = 32'd66;
      default: nonce_offset = 32'((1 << (7 - loop_log2)) + 1);
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. A byte is taken when valid && ready_c; ready_c is also
// high in the last STOP cycle so consecutive bytes follow with no idle gap.
module uart_tx_byte
  import mining_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       osc_clk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready_c,
  output logic       done_c,
  output logic       txd
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             txd_q, txd_d;
  logic             bit_end_c;

  always_ff @(posedge osc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UART_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      txd_q   <= txd_d;
    end
  end

  // One down-counter paces every bit; txd_d is the line level of the next state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    txd_d     = txd_q;
    ready_c   = 1'b0;
    done_c    = 1'b0;
    bit_end_c = (cnt_q == '0);
    if (!bit_end_c && state_q != UART_IDLE) cnt_d = cnt_q - CNT_W'(1);
    case (state_q)
      UART_IDLE: begin
        ready_c = 1'b1;
        txd_d   = 1'b1;
        if (valid) begin
          shreg_d = data;
          cnt_d   = CNT_MAX;
          state_d = UART_START;
          txd_d   = 1'b0;
        end
      end
      UART_START: begin
        if (bit_end_c) begin
          cnt_d   = CNT_MAX;
          bit_d   = '0;
          state_d = UART_DATA;
          txd_d   = shreg_q[0];
        end
      end
      UART_DATA: begin
        if (bit_end_c) begin
          cnt_d = CNT_MAX;
          if (bit_q == 3'd7) begin
            state_d = UART_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = {1'b0, shreg_q[7:1]};
            txd_d   = shreg_q[1];
          end
        end
      end
      UART_STOP: begin
        if (bit_end_c) begin
          ready_c = 1'b1;
          done_c  = 1'b1;
          if (valid) begin
            shreg_d = data;
            cnt_d   = CNT_MAX;
            state_d = UART_START;
            txd_d   = 1'b0;
          end else begin
            state_d = UART_IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = UART_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  assign txd = txd_q;

endmodule

// File: rtl/golden_nonce_uart_reporter.sv
// Detects new golden nonces from the miner, removes the pipeline offset,
// queues them and sends each as a 5-byte frame (sync + nonce MSB first).
module golden_nonce_uart_reporter
  import mining_pkg::*;
#(
  parameter int unsigned LOOP_LOG2       = 5,
  parameter int unsigned CLKS_PER_BIT    = 868,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2,
  parameter logic [7:0]  SYNC_BYTE       = SYNC_BYTE_DEFAULT
) (
  input  logic        osc_clk,
  input  logic        rst_n,
  input  logic        hit,
  input  logic [31:0] hit_nonce,
  output logic        txd,
  output logic        busy,
  output logic        overflow,
  output logic [15:0] report_count
);

  localparam int unsigned DEPTH       = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned PTR_W       = FIFO_DEPTH_LOG2;
  localparam int unsigned CNT_W       = FIFO_DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] FULL   = CNT_W'(DEPTH);
  localparam logic [31:0] NONCE_OFFSET = nonce_offset(LOOP_LOG2);
  localparam logic [2:0]  FRAME_BYTES  = 3'd5;

  logic             prev_hit_q, prev_hit_d;
  logic [31:0]      prev_nonce_q, prev_nonce_d;
  logic             evt_q, evt_d;
  logic [31:0]      corr_q, corr_d;
  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  seq_state_e       seq_q, seq_d;
  logic [31:0]      buf_q, buf_d;
  logic [2:0]       idx_q, idx_d;
  logic [15:0]      report_q, report_d;
  logic             busy_q, busy_d;

  logic             pop_c, push_c, fifo_full_c, fifo_empty_c;
  logic             tx_valid_c, tx_ready_c, tx_done_c;
  logic [7:0]       tx_data_c;

  always_ff @(posedge osc_clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_hit_q   <= 1'b0;
      prev_nonce_q <= '0;
      evt_q        <= 1'b0;
      corr_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      seq_q        <= SEQ_IDLE;
      buf_q        <= '0;
      idx_q        <= '0;
      report_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      prev_hit_q   <= prev_hit_d;
      prev_nonce_q <= prev_nonce_d;
      evt_q        <= evt_d;
      corr_q       <= corr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      seq_q        <= seq_d;
      buf_q        <= buf_d;
      idx_q        <= idx_d;
      report_q     <= report_d;
      busy_q       <= busy_d;
    end
  end

  // FIFO storage needs no reset; count_q alone defines what is valid.
  always_ff @(posedge osc_clk) begin
    if (push_c) mem_q[wr_ptr_q] <= corr_q;
  end

  always_comb begin
    prev_hit_d   = hit;
    prev_nonce_d = hit_nonce;
    evt_d        = hit && (!prev_hit_q || (hit_nonce != prev_nonce_q));
    corr_d       = hit_nonce - NONCE_OFFSET;

    fifo_empty_c = (count_q == '0);
    fifo_full_c  = (count_q == FULL);

    seq_d      = seq_q;
    buf_d      = buf_q;
    idx_d      = idx_q;
    report_d   = report_q;
    pop_c      = 1'b0;
    tx_valid_c = 1'b0;
    tx_data_c  = SYNC_BYTE;

    // idx_q counts bytes already handed to the serializer in this frame.
    case (seq_q)
      SEQ_IDLE: begin
        tx_valid_c = !fifo_empty_c;
        if (tx_valid_c && tx_ready_c) begin
          pop_c = 1'b1;
          buf_d = mem_q[rd_ptr_q];
          idx_d = 3'd1;
          seq_d = SEQ_SEND;
        end
      end
      SEQ_SEND: begin
        tx_valid_c = (idx_q < FRAME_BYTES);
        tx_data_c  = buf_q[31:24];
        if (tx_valid_c && tx_ready_c) begin
          buf_d = {buf_q[23:0], 8'h00};
          idx_d = idx_q + 3'd1;
        end
        if (tx_done_c && idx_q == FRAME_BYTES) begin
          report_d = report_q + 16'd1;
          seq_d    = SEQ_IDLE;
        end
      end
      default: seq_d = SEQ_IDLE;
    endcase

    // A same-cycle pop frees the slot the push needs.
    push_c     = evt_q && (!fifo_full_c || pop_c);
    overflow_d = overflow_q || (evt_q && fifo_full_c && !pop_c);
    count_d    = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    wr_ptr_d   = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    busy_d     = (seq_d != SEQ_IDLE) || (count_d != '0);
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .osc_clk (osc_clk),
    .rst_n   (rst_n),
    .valid   (tx_valid_c),
    .data    (tx_data_c),
    .ready_c (tx_ready_c),
    .done_c  (tx_done_c),
    .txd     (txd)
  );

  assign busy         = busy_q;
  assign overflow     = overflow_q;
  assign report_count = report_q;

endmodule
